// File: rtl/dbg_sequencer.sv
// Debug execution sequencer: halts the CPU, releases single fetched or
// injected instructions, and acknowledges bridge commands with a 4-phase handshake.
module dbg_sequencer #(
    parameter int TMO_CYCLES = 255,
    parameter int CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             step_mode,
    input  logic             inject_req,
    input  logic [1:0]       dbg_cmd,
    input  logic [15:0]      inject_instr,
    input  logic             cpu_idle,
    input  logic             cpu_retire,
    output logic             inject_ack,
    output logic             halt_req,
    output logic             exec_go,
    output logic             exec_sel,
    output logic [15:0]      override_instr,
    output logic             tmo_flag,
    output logic [CNT_W-1:0] exec_cnt
);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] HALTING = 3'd1;
    localparam logic [2:0] HALTED  = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] ACK     = 3'd4;

    localparam logic [1:0] CMD_INJECT = 2'd1;
    localparam logic [1:0] CMD_STEP   = 2'd2;

    localparam int               TMO_W    = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             accept;
    logic             retire;
    logic             timeout;
    logic             halt_nxt;
    logic             cmd_exec;

    assign cmd_exec = (dbg_cmd == CMD_INJECT) || (dbg_cmd == CMD_STEP);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        retire    = 1'b0;
        timeout   = 1'b0;
        case (state)
            RUN: begin
                if (step_mode)
                    state_nxt = HALTING;
                else if (inject_req && !inject_ack)
                    state_nxt = ACK;
            end
            HALTING: begin
                if (!step_mode)
                    state_nxt = RUN;
                else if (cpu_idle)
                    state_nxt = HALTED;
            end
            HALTED: begin
                if (!step_mode) begin
                    state_nxt = RUN;
                end else if (inject_req && !inject_ack) begin
                    accept    = 1'b1;
                    state_nxt = cmd_exec ? EXEC : ACK;
                end
            end
            EXEC: begin
                // A retire on the final timeout cycle still counts as a retire.
                if (cpu_retire) begin
                    retire    = 1'b1;
                    state_nxt = ACK;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!inject_req)
                    state_nxt = step_mode ? HALTED : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // ACK keeps whatever stall level it was entered with, so a
    // command serviced from RUN never stalls the CPU.
    always_comb begin
        case (state_nxt)
            RUN:     halt_nxt = 1'b0;
            ACK:     halt_nxt = (state == ACK) ? halt_req : (state != RUN);
            default: halt_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= RUN;
            inject_ack     <= 1'b0;
            halt_req       <= 1'b0;
            exec_go        <= 1'b0;
            exec_sel       <= 1'b0;
            override_instr <= 16'h0000;
            tmo_flag       <= 1'b0;
            exec_cnt       <= '0;
            tmo_cnt        <= '0;
        end else begin
            state    <= state_nxt;
            halt_req <= halt_nxt;
            exec_go  <= accept && cmd_exec;

            if (accept) begin
                tmo_flag <= 1'b0;
                if (dbg_cmd == CMD_INJECT)
                    override_instr <= inject_instr;
            end

            if (accept && cmd_exec) begin
                exec_sel <= (dbg_cmd == CMD_INJECT);
                tmo_cnt  <= '0;
            end else if (state == EXEC) begin
                if (retire || timeout)
                    exec_sel <= 1'b0;
                else
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (retire)
                exec_cnt <= exec_cnt + CNT_W'(1);
            if (timeout)
                tmo_flag <= 1'b1;

            // Completion acks immediately; plain ACK entries ack one cycle later.
            inject_ack <= ((state == ACK) || retire || timeout) && inject_req;
        end
    end

endmodule
